pipe_reg_slr: RTL and testbench

PIPE_REG_SLR -- requirements
Module: pipe_reg_slr

---
 rtl/pipe_reg_slr.sv | 92 +++++++++
 tb/tb_pipe_reg_slr.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_slr.sv
// Elastic register pipeline with bubble collapse: each stage holds one item and advances
// whenever the stage ahead is empty or draining, so throughput is one item per cycle.
module pipe_reg_slr #(
    parameter int unsigned        WIDTH     = 8,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] load;
    logic [DEPTH:0]   acc;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // acc[i]: stage i can take a new item this cycle (empty, or its item moves on)
    always_comb begin
        acc[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc[i] = !valid_q[i] | acc[i+1];
        end
    end

    assign in_ready = acc[0] & !flush;

    always_comb begin
        load[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = acc[i] & valid_q[i-1] & !flush;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
            if (load[i]) begin
                data_d[i]  = (i == 0) ? in_data : data_q[(i == 0) ? 0 : i - 1];
                valid_d[i] = 1'b1;
            end else if (valid_q[i] && acc[i+1]) begin
                valid_d[i] = 1'b0;
            end
            // Flush drops occupancy only; payload registers keep their contents
            if (flush) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_slr.sv
// Directed bench for pipe_reg_slr (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_pipe_reg_slr;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [2:0] count;

    int n_vec = 0;
    int n_err = 0;

    pipe_reg_slr #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset with a pending input: nothing may be captured
        tick();
        check("rst_in_ready", in_ready, 1);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_count", count, 0);

        // Latency through an empty pipe
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        #1;
        check("lat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            #1;
            check($sformatf("lat_early_valid_c%0d", c), out_valid, 0);
            tick();
        end
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 8'h11);
        check("lat_count4", count, 1);
        tick();
        check("lat_count5", count, 0);
        check("lat_drained", out_valid, 0);

        // Fill and stall
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #1;
            check($sformatf("fill_in_ready_%0d", k), in_ready, (k <= 4) ? 1 : 0);
            if (k <= 4) tick();
        end
        check("fill_count", count, 4);
        check("fill_out_data", out_data, 8'h01);
        tick();
        check("stall_count", count, 4);
        check("stall_out_data", out_data, 8'h01);
        check("stall_in_ready", in_ready, 0);

        // Full throughput: drain and fill every cycle
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_data  = 8'(5 + j);
            #1;
            check($sformatf("thru_in_ready_%0d", j), in_ready, 1);
            check($sformatf("thru_out_valid_%0d", j), out_valid, 1);
            check($sformatf("thru_out_data_%0d", j), out_data, 8'(j + 1));
            check($sformatf("thru_count_%0d", j), count, 4);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_flush_head", out_data, 8'h06);
        tick();
        check("pre_flush_count", count, 3);

        // Flush with concurrent in/out traffic
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_head_valid", out_valid, 1);
        check("flush_head_data", out_data, 8'h07);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_data_kept", out_data, 8'h07);

        // Bubble collapse: 0x21, idle, 0x22 with the output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h22;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bub_count", count, 2);
        check("bub_head", out_data, 8'h21);
        out_ready = 1'b1;
        tick();
        check("bub_next_valid", out_valid, 1);
        check("bub_next_data", out_data, 8'h22);
        check("bub_next_count", count, 1);
        tick();
        check("bub_empty", count, 0);

        // Reset beats flush and handshakes; in-flight items discarded
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        tick();
        tick();
        tick();
        tick();
        check("rst2_loaded", count, 4);
        rst       = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("rst2_count", count, 0);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_out_data", out_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
